ca_prng_engine: RTL and testbench

//  Parametrised 1-D cellular-automaton PRNG. Runtime-selectable Wolfram rule and boundary mode.

---
 rtl/ca_prng_pkg.sv | 15 +
 rtl/ca_prng_engine_if.sv | 28 ++
 rtl/ca_next_gen.sv | 31 +++
 rtl/ca_prng_engine.sv | 159 +++++++++++++++
 tb/tb_ca_prng_engine.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ca_prng_pkg.sv
// Shared types and constants for the cellular-automaton PRNG engine.
package ca_prng_pkg;

    typedef enum logic [1:0] {
        CA_IDLE   = 2'd0,
        CA_WARMUP = 2'd1,
        CA_RUN    = 2'd2
    } ca_fsm_t;

    localparam logic [7:0] RULE_30  = 8'd30;
    localparam logic [7:0] RULE_90  = 8'd90;
    localparam logic [7:0] RULE_150 = 8'd150;
    localparam logic [7:0] RULE_182 = 8'd182;

endpackage : ca_prng_pkg

// File: rtl/ca_prng_engine_if.sv
// Config/seed load port and valid/ready random-word stream of the CA PRNG.
interface ca_prng_engine_if #(
    parameter int unsigned N      = 32,
    parameter int unsigned SKIP_W = 4
);
    logic              load;
    logic [N-1:0]      seed_in;
    logic [7:0]        rule_in;
    logic              periodic_in;
    logic [SKIP_W-1:0] skip_in;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      data_out;
    logic              busy;
    logic              stuck;

    // Source/consumer side
    modport master (
        output load, seed_in, rule_in, periodic_in, skip_in, out_ready,
        input  out_valid, data_out, busy, stuck
    );

    // Engine side
    modport slave (
        input  load, seed_in, rule_in, periodic_in, skip_in, out_ready,
        output out_valid, data_out, busy, stuck
    );
endinterface : ca_prng_engine_if

// File: rtl/ca_next_gen.sv
// Combinational next generation of a 1-D elementary CA: next[i] = rule[{L,C,R}].
module ca_next_gen #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_state,
    input  logic [7:0]   i_rule,
    input  logic         i_periodic,
    output logic [N-1:0] o_next
);

    for (genvar g = 0; g < N; g++) begin : g_cell
        logic w_l;
        logic w_r;

        // Edge cells wrap around or read 0 depending on boundary mode
        if (g == N - 1) begin : g_l_edge
            assign w_l = i_periodic & i_state[0];
        end else begin : g_l_in
            assign w_l = i_state[g + 1];
        end

        if (g == 0) begin : g_r_edge
            assign w_r = i_periodic & i_state[N - 1];
        end else begin : g_r_in
            assign w_r = i_state[g - 1];
        end

        assign o_next[g] = i_rule[{w_l, i_state[g], w_r}];
    end

endmodule : ca_next_gen

// File: rtl/ca_prng_engine.sv
// Cellular-automaton PRNG: load/warm-up/run FSM, decimation, stuck detection.
// Optional CA_PRNG_AUTO_RESEED_EN: reseed from rotated seed on a fixed point.
module ca_prng_engine
    import ca_prng_pkg::*;
#(
    parameter int unsigned N            = 32,
    parameter logic [7:0]  DEFAULT_RULE = RULE_182,
    parameter int unsigned WARMUP       = 32,
    parameter int unsigned SKIP_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    ca_prng_engine_if.slave  bus
);

    localparam int unsigned WC_W = $clog2(WARMUP + 2);

    ca_fsm_t           r_fsm;
    logic [N-1:0]      r_state;
    logic [7:0]        r_rule;
    logic              r_periodic;
    logic [SKIP_W-1:0] r_skip;
    logic [SKIP_W-1:0] r_cnt;
    logic [WC_W-1:0]   r_warm;
    logic [N-1:0]      r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_stuck;

    logic [N-1:0]      w_next;
    logic              w_fixed;
    logic              w_adv;

    ca_next_gen #(.N(N)) u_next_gen (
        .i_state    (r_state),
        .i_rule     (r_rule),
        .i_periodic (r_periodic),
        .o_next     (w_next)
    );

    assign w_fixed = (w_next == r_state);
    assign w_adv   = !r_valid || bus.out_ready;

`ifdef CA_PRNG_AUTO_RESEED_EN
    localparam int unsigned RS_W = $clog2(N);

    logic [N-1:0]     r_seed;
    logic [RS_W-1:0]  r_rs_cnt;
    logic [RS_W:0]    w_amt;
    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_reseed;
    logic [RS_W-1:0]  w_rs_inc;

    // Rotation amount runs 1..N; a rotate by N returns the seed itself
    assign w_amt    = {1'b0, r_rs_cnt} + (RS_W + 1)'(1);
    assign w_dbl    = {r_seed, r_seed} << w_amt;
    assign w_reseed = w_dbl[2*N-1:N];
    assign w_rs_inc = (r_rs_cnt == RS_W'(N - 1)) ? '0 : r_rs_cnt + RS_W'(1);
`endif

    // Main FSM, CA state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fsm      <= CA_IDLE;
            r_state    <= '0;
            r_rule     <= DEFAULT_RULE;
            r_periodic <= 1'b1;
            r_skip     <= '0;
            r_cnt      <= '0;
            r_warm     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_stuck    <= 1'b0;
`ifdef CA_PRNG_AUTO_RESEED_EN
            r_seed     <= '0;
            r_rs_cnt   <= '0;
`endif
        end else if (bus.load) begin
            r_state    <= bus.seed_in;
            r_rule     <= bus.rule_in;
            r_periodic <= bus.periodic_in;
            r_skip     <= bus.skip_in;
            r_cnt      <= '0;
            r_warm     <= WC_W'(WARMUP);
            r_valid    <= 1'b0;
            r_stuck    <= 1'b0;
`ifdef CA_PRNG_AUTO_RESEED_EN
            r_seed     <= bus.seed_in;
            r_rs_cnt   <= '0;
`endif
            if (WARMUP > 0) begin
                r_fsm  <= CA_WARMUP;
                r_busy <= 1'b1;
            end else begin
                r_fsm  <= CA_RUN;
                r_busy <= 1'b0;
            end
        end else begin
`ifdef CA_PRNG_AUTO_RESEED_EN
            r_stuck <= 1'b0;
`endif
            case (r_fsm)
                CA_WARMUP: begin
`ifdef CA_PRNG_AUTO_RESEED_EN
                    if (w_fixed) begin
                        r_state  <= w_reseed;
                        r_rs_cnt <= w_rs_inc;
                        r_stuck  <= 1'b1;
                    end else
`endif
                    begin
                        r_state <= w_next;
                        if (w_fixed) r_stuck <= 1'b1;
                        r_warm  <= r_warm - WC_W'(1);
                        if (r_warm == WC_W'(1)) begin
                            r_fsm  <= CA_RUN;
                            r_busy <= 1'b0;
                        end
                    end
                end
                CA_RUN: begin
                    // Under backpressure the held word and CA state stay frozen
                    if (w_adv) begin
`ifdef CA_PRNG_AUTO_RESEED_EN
                        if (w_fixed) begin
                            r_state  <= w_reseed;
                            r_rs_cnt <= w_rs_inc;
                            r_stuck  <= 1'b1;
                            r_valid  <= 1'b0;
                        end else
`endif
                        begin
                            r_state <= w_next;
                            if (w_fixed) r_stuck <= 1'b1;
                            if (r_cnt == r_skip) begin
                                r_data  <= w_next;
                                r_valid <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_valid <= 1'b0;
                                r_cnt   <= r_cnt + SKIP_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.data_out  = r_data;
    assign bus.busy      = r_busy;
    assign bus.stuck     = r_stuck;

endmodule : ca_prng_engine

// File: tb/tb_ca_prng_engine.sv
// Directed bench for ca_prng_engine: two instances, WARMUP=0 and WARMUP=3.
module tb_ca_prng_engine;
    import ca_prng_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;
    logic [7:0] m;

    always #5 clk = ~clk;

    ca_prng_engine_if #(.N(8), .SKIP_W(4)) ifa ();
    ca_prng_engine_if #(.N(8), .SKIP_W(4)) ifb ();

    ca_prng_engine #(.N(8), .DEFAULT_RULE(8'd182), .WARMUP(0), .SKIP_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa)
    );
    ca_prng_engine #(.N(8), .DEFAULT_RULE(8'd182), .WARMUP(3), .SKIP_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb)
    );

    // Reference generation built from shifted neighbour vectors
    function automatic logic [7:0] ca_ref(input logic [7:0] s, input logic [7:0] rule,
                                          input logic per);
        logic [7:0] lv;
        logic [7:0] rv;
        logic [7:0] o;
        logic [2:0] idx;
        lv = {per & s[0], s[7:1]};
        rv = {s[6:0], per & s[7]};
        o  = '0;
        for (int i = 0; i < 8; i++) begin
            idx  = {lv[i], s[i], rv[i]};
            o[i] = rule[idx];
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic [7:0] s, input logic [7:0] r, input logic p,
                          input logic [3:0] k);
        ifa.seed_in = s; ifa.rule_in = r; ifa.periodic_in = p; ifa.skip_in = k;
        ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] s, input logic [7:0] r, input logic p,
                          input logic [3:0] k);
        ifb.seed_in = s; ifb.rule_in = r; ifb.periodic_in = p; ifb.skip_in = k;
        ifb.load = 1'b1;
        tick();
        ifb.load = 1'b0;
    endtask

    initial begin
        ifa.load = 1'b0; ifa.seed_in = '0; ifa.rule_in = '0; ifa.periodic_in = 1'b0;
        ifa.skip_in = '0; ifa.out_ready = 1'b0;
        ifb.load = 1'b0; ifb.seed_in = '0; ifb.rule_in = '0; ifb.periodic_in = 1'b0;
        ifb.skip_in = '0; ifb.out_ready = 1'b0;

        // Reset, then idle without load
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (100) tick();
        chk("rst_valid", ifa.out_valid, 1'b0);
        chk("rst_data", ifa.data_out, 8'h00);
        chk("rst_stuck", ifa.stuck, 1'b0);
        chk("rst_busy", ifa.busy, 1'b0);
        chk("rst_b_busy", ifb.busy, 1'b0);
        chk("rst_b_valid", ifb.out_valid, 1'b0);

        // Rule 30, periodic, one word per cycle
        ifa.out_ready = 1'b1;
        load_a(8'h01, RULE_30, 1'b1, 4'd0);
        chk("r30p_after_load_valid", ifa.out_valid, 1'b0);
        tick();
        chk("r30p_first_word", ifa.data_out, 8'h83);
        chk("r30p_first_valid", ifa.out_valid, 1'b1);
        m = 8'h83;
        for (int i = 0; i < 4; i++) begin
            m = ca_ref(m, RULE_30, 1'b1);
            tick();
            chk("r30p_stream_data", ifa.data_out, m);
            chk("r30p_stream_valid", ifa.out_valid, 1'b1);
        end

        // Rule 30, null boundary
        load_a(8'h01, RULE_30, 1'b0, 4'd0);
        tick();
        chk("r30n_first_word", ifa.data_out, 8'h03);
        m = 8'h03;
        for (int i = 0; i < 3; i++) begin
            m = ca_ref(m, RULE_30, 1'b0);
            tick();
            chk("r30n_stream_data", ifa.data_out, m);
        end

        // Backpressure: word and valid frozen, nothing lost on release
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", ifa.data_out, m);
            chk("bp_hold_valid", ifa.out_valid, 1'b1);
        end
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m = ca_ref(m, RULE_30, 1'b0);
            tick();
            chk("bp_release_data", ifa.data_out, m);
            chk("bp_release_valid", ifa.out_valid, 1'b1);
        end

        // Decimation skip=3, rule 90: one word every 4 generations
        load_a(8'h01, RULE_90, 1'b1, 4'd3);
        m = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            m = ca_ref(m, RULE_90, 1'b1);
            tick();
            if (k % 4 == 0) begin
                chk("skip_word_data", ifa.data_out, m);
                chk("skip_word_valid", ifa.out_valid, 1'b1);
            end else begin
                chk("skip_gap_valid", ifa.out_valid, 1'b0);
            end
        end

        // Rule 0 collapses to all-zero fixed point
        load_a(8'hA5, 8'd0, 1'b1, 4'd0);
        tick();
        chk("r0_gen1_stuck", ifa.stuck, 1'b0);
        chk("r0_gen1_data", ifa.data_out, 8'h00);
        tick();
        chk("r0_fixed_stuck", ifa.stuck, 1'b1);
`ifdef CA_PRNG_AUTO_RESEED_EN
        tick();
        chk("r0_reseed_stuck_pulse", ifa.stuck, 1'b0);
`else
        repeat (3) tick();
        chk("r0_stuck_sticky", ifa.stuck, 1'b1);
`endif

        // Warm-up instance: busy window, first word, then load over a pending word
        load_b(8'h01, RULE_30, 1'b1, 4'd0);
        chk("wu_busy_load", ifb.busy, 1'b1);
        m = 8'h01;
        for (int k = 1; k <= 3; k++) begin
            m = ca_ref(m, RULE_30, 1'b1);
            tick();
            chk("wu_busy", ifb.busy, (k < 3) ? 1'b1 : 1'b0);
            chk("wu_valid_low", ifb.out_valid, 1'b0);
        end
        m = ca_ref(m, RULE_30, 1'b1);
        tick();
        chk("wu_first_valid", ifb.out_valid, 1'b1);
        chk("wu_first_data", ifb.data_out, m);
        tick();
        chk("wu_hold_valid", ifb.out_valid, 1'b1);

        load_b(8'h10, RULE_150, 1'b0, 4'd1);
        chk("reload_valid_drop", ifb.out_valid, 1'b0);
        chk("reload_busy", ifb.busy, 1'b1);
        ifb.out_ready = 1'b1;
        m = 8'h10;
        for (int k = 1; k <= 5; k++) begin
            m = ca_ref(m, RULE_150, 1'b0);
            tick();
            if (k == 5) begin
                chk("reload_word_valid", ifb.out_valid, 1'b1);
                chk("reload_word_data", ifb.data_out, m);
            end else begin
                chk("reload_gap_valid", ifb.out_valid, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ca_prng_engine
